// File: rtl/fifo_access_arbiter.sv
// Round-robin write arbiter and read gate in front of a flag-less 8-bit FIFO.
// Occupancy is tracked here on the accept edge; all FIFO strobes are registered.
module fifo_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_read_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data_out,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty,
    output logic [2:0]                    grant_id
);

    logic [2:0]            rr_ptr_r;
    logic                  rd_pend_r;
    logic [NUM_REQ-1:0]    mask_hi_s;
    logic [NUM_REQ-1:0]    req_hi_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [2:0]            win_idx_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        return v & (~v + {{(NUM_REQ-1){1'b0}}, 1'b1});
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == {CW{1'b0}});

    // Round-robin grant: lowest requester above rr_ptr wins, else wrap to the lowest overall.
    always_comb begin
        mask_hi_s  = {NUM_REQ{1'b0}};
        win_idx_s  = 3'd0;
        win_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_hi_s[i] = (i > int'(rr_ptr_r));
        end
        req_hi_s  = req_valid & mask_hi_s;
        grant_s   = (req_hi_s != {NUM_REQ{1'b0}}) ? lowest_set(req_hi_s) : lowest_set(req_valid);
        req_ready = full ? {NUM_REQ{1'b0}} : grant_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s  = win_idx_s | ({3{req_ready[i]}} & 3'(i));
            win_data_s = win_data_s | ({DATA_WIDTH{req_ready[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        wr_acc_s = |(req_valid & req_ready);
        rd_acc_s = rd_req & ~empty;
    end

    // Strobe generation, read-data pipeline and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_write_en <= 1'b0;
            fifo_read_en  <= 1'b0;
            rd_pend_r     <= 1'b0;
            rd_valid      <= 1'b0;
            fifo_data_in  <= {DATA_WIDTH{1'b0}};
            rd_data       <= {DATA_WIDTH{1'b0}};
            count         <= {CW{1'b0}};
            grant_id      <= 3'd0;
            rr_ptr_r      <= 3'(NUM_REQ - 1);
        end else begin
            fifo_write_en <= wr_acc_s;
            fifo_read_en  <= rd_acc_s;
            // FIFO data appears the cycle after its read strobe, hence one extra stage.
            rd_pend_r     <= fifo_read_en;
            rd_valid      <= rd_pend_r;
            if (wr_acc_s) begin
                fifo_data_in <= win_data_s;
                rr_ptr_r     <= win_idx_s;
                grant_id     <= win_idx_s;
            end
            if (rd_pend_r) begin
                rd_data <= fifo_data_out;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter: vector table, directed boundary sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fifo_access_arbiter;
    localparam int N = 4, DW = 8, DEPTH = 16, CW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          rd_req = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data, fifo_data_in;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_write_en, fifo_read_en;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [2:0]    grant_id;

    int checks = 0;
    int errors = 0;

    fifo_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
        .fifo_read_en(fifo_read_en), .fifo_data_out(fifo_data_out),
        .count(count), .full(full), .empty(empty), .grant_id(grant_id)
    );

    // Behavioural FIFO attached to the strobes
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (!rst) begin
            fq.delete();
            fifo_data_out <= '0;
        end else begin
            if (fifo_read_en) begin
                if (fq.size() > 0) fifo_data_out <= fq.pop_front();
                else fifo_data_out <= 8'hEE;
            end
            if (fifo_write_en) fq.push_back(fifo_data_in);
        end
    end

    // Reference model state
    int            m_last = N - 1;
    logic [DW-1:0] m_q[$];
    bit            sv[2];
    logic [DW-1:0] sd[2];
    logic          e_we, e_re, e_rv;
    logic [DW-1:0] e_din, e_rd;
    logic [2:0]    e_gid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rv, input logic [N*DW-1:0] d,
                        input logic rr, output logic [N-1:0] rdy_seen);
        int g;
        logic [N-1:0] exp_rdy;
        bit acc_r;
        @(negedge clk);
        rst = r; req_valid = rv; req_data = d; rd_req = rr;
        #1;
        rdy_seen = req_ready;
        g = -1;
        if (m_q.size() < DEPTH)
            for (int k = 1; k <= N; k++)
                if (g < 0 && rv[(m_last + k) % N]) g = (m_last + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        acc_r = rr && (m_q.size() > 0);
        if (r) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("full_pre", full, m_q.size() == DEPTH);
            chk("empty_pre", empty, m_q.size() == 0);
        end
        @(posedge clk);
        #1;
        if (!r) begin
            m_last = N - 1; m_q.delete(); sv = '{0, 0};
            e_we = 0; e_re = 0; e_rv = 0; e_din = 0; e_rd = 0; e_gid = 0;
        end else begin
            e_rv = sv[1];
            if (sv[1]) e_rd = sd[1];
            sv[1] = sv[0]; sd[1] = sd[0];
            sv[0] = acc_r; sd[0] = 8'h00;
            if (acc_r) sd[0] = m_q.pop_front();
            e_we = (g >= 0);
            if (g >= 0) begin
                e_din = d[g*DW +: DW];
                e_gid = 3'(g);
                m_last = g;
                m_q.push_back(e_din);
            end
            e_re = acc_r;
        end
        chk("count", count, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("fifo_write_en", fifo_write_en, e_we);
        chk("fifo_data_in", fifo_data_in, e_din);
        chk("fifo_read_en", fifo_read_en, e_re);
        chk("grant_id", grant_id, e_gid);
        chk("rd_valid", rd_valid, e_rv);
        chk("rd_data", rd_data, e_rd);
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  rv;
        logic [31:0] d;
        logic        rd;
        logic [3:0]  rdy;
        logic [4:0]  cnt;
        logic        we;
        logic [7:0]  din;
        logic [2:0]  gid;
        logic        rvld;
        logic [7:0]  rdat;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [N-1:0] seen;
        int wp, rp;
        vt[0] = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
        vt[1] = vt[0];
        vt[2] = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
        vt[3] = '{1'b1, 4'b0001, 32'h0000000A, 1'b0, 4'b0001, 5'd1, 1'b1, 8'h0A, 3'd0, 1'b0, 8'h00};
        vt[4] = '{1'b1, 4'b0000, 32'h0, 1'b1, 4'b0000, 5'd0, 1'b0, 8'h0A, 3'd0, 1'b0, 8'h00};
        vt[5] = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0, 8'h0A, 3'd0, 1'b0, 8'h00};
        vt[6] = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0, 8'h0A, 3'd0, 1'b1, 8'h0A};
        vt[7] = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0, 8'h0A, 3'd0, 1'b0, 8'h0A};
        vt[8] = vt[0];
        for (int j = 0; j < 8; j++)
            vt[9+j] = '{1'b1, 4'b1111, 32'h40302010, 1'b0, 4'(1 << (j % 4)), 5'(j + 1), 1'b1,
                        8'(16 * ((j % 4) + 1)), 3'(j % 4), 1'b0, 8'h00};

        for (int i = 0; i < 17; i++) begin
            step(vt[i].r, vt[i].rv, vt[i].d, vt[i].rd, seen);
            chk($sformatf("tbl%0d_rdy", i), seen, vt[i].rdy);
            chk($sformatf("tbl%0d_count", i), count, vt[i].cnt);
            chk($sformatf("tbl%0d_we", i), fifo_write_en, vt[i].we);
            chk($sformatf("tbl%0d_din", i), fifo_data_in, vt[i].din);
            chk($sformatf("tbl%0d_gid", i), grant_id, vt[i].gid);
            chk($sformatf("tbl%0d_rvld", i), rd_valid, vt[i].rvld);
            chk($sformatf("tbl%0d_rdat", i), rd_data, vt[i].rdat);
        end

        // Fill to full, then a write and read collide at the full boundary
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0001, 32'h00000050 + i, 1'b0, seen);
        chk("full_at_16", full, 1'b1);
        chk("count_16", count, 5'd16);
        step(1'b1, 4'b0010, 32'h00006600, 1'b1, seen);
        chk("full_rdy_blocked", seen, 4'b0000);
        chk("full_count_15", count, 5'd15);
        chk("full_read_en", fifo_read_en, 1'b1);
        step(1'b1, 4'b0010, 32'h00006600, 1'b0, seen);
        chk("full_rdy_next", seen, 4'b0010);
        chk("full_count_16", count, 5'd16);

        // Drain, then read and write collide at the empty boundary
        for (int i = 0; i < 19; i++) step(1'b1, 4'b0000, 32'h0, 1'b1, seen);
        chk("drained_empty", empty, 1'b1);
        step(1'b1, 4'b0100, 32'h00C30000, 1'b1, seen);
        chk("empty_read_en", fifo_read_en, 1'b0);
        chk("empty_write_en", fifo_write_en, 1'b1);
        chk("empty_count_1", count, 5'd1);
        step(1'b1, 4'b0000, 32'h0, 1'b1, seen);
        chk("empty_rd_accept", fifo_read_en, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b0, seen);
        step(1'b1, 4'b0000, 32'h0, 1'b0, seen);
        chk("empty_rd_valid", rd_valid, 1'b1);
        chk("empty_rd_data", rd_data, 8'hC3);

        // Reset with five entries stored and a read in flight
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1000, 32'h77000000 + i, 1'b0, seen);
        chk("mid_count_5", count, 5'd5);
        step(1'b1, 4'b0000, 32'h0, 1'b1, seen);
        step(1'b0, 4'b0000, 32'h0, 1'b0, seen);
        chk("rst_count", count, 5'd0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_read_en", fifo_read_en, 1'b0);
        chk("rst_write_en", fifo_write_en, 1'b0);
        step(1'b1, 4'b1111, 32'h44332211, 1'b0, seen);
        chk("rst_first_grant", seen, 4'b0001);
        chk("rst_no_late_valid", rd_valid, 1'b0);

        // Randomized traffic in phases of differing write/read pressure
        for (int p = 0; p < 12; p++) begin
            case (p % 3)
                0: begin wp = 85; rp = 25; end
                1: begin wp = 20; rp = 85; end
                default: begin wp = 70; rp = 70; end
            endcase
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 99) < wp) ? 4'($urandom) : 4'b0000,
                     32'($urandom),
                     ($urandom_range(0, 99) < rp),
                     seen);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
